// File: rtl/fibb_pkg.sv
// fibb_pkg: shared state encoding, default requester count and BCD digit helper
package fibb_pkg;

    localparam int N_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    // first requester at or after the pointer wins; later ones are masked by o_valid
    always_comb begin
        int j;
        j       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(i_ptr) + i) % N;
            if (!o_valid && i_req[j]) begin
                o_valid  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/fibb_scheduler.sv
// fibb_scheduler: shares one BCD Fibonacci engine among N_REQ requesters in round-robin order.
// Optional FIBB_SCHED_BCD_CHECK_EN rejects non-BCD operands with a 9999 result and o_err.
module fibb_scheduler
    import fibb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [4*N_REQ-1:0] i_bcd1_n,
    input  logic [4*N_REQ-1:0] i_bcd0_n,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_done,
    output logic [3:0]         o_bcd3,
    output logic [3:0]         o_bcd2,
    output logic [3:0]         o_bcd1,
    output logic [3:0]         o_bcd0,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_eng_start,
    output logic [3:0]         o_eng_bcd1_n,
    output logic [3:0]         o_eng_bcd0_n,
    input  logic               i_eng_ready,
    input  logic               i_eng_done_tick,
    input  logic [3:0]         i_eng_bcd3,
    input  logic [3:0]         i_eng_bcd2,
    input  logic [3:0]         i_eng_bcd1,
    input  logic [3:0]         i_eng_bcd0
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [3:0]         op1_q, op1_d;
    logic [3:0]         op0_q, op0_d;
    logic [15:0]        res_q, res_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [3:0]         sel1;
    logic [3:0]         sel0;
    logic               bad;
    logic               take;

    rr_arbiter #(.N(N_REQ), .W(IDX_W)) u_arb (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_gnt   (arb_gnt),
        .o_idx   (arb_idx),
        .o_valid (arb_valid)
    );

    assign sel1 = i_bcd1_n[4*arb_idx +: 4];
    assign sel0 = i_bcd0_n[4*arb_idx +: 4];
    assign take = (state_q == IDLE) && i_eng_ready && arb_valid;

`ifdef FIBB_SCHED_BCD_CHECK_EN
    logic err_q, err_d;

    assign bad = !(bcd_digit_ok(sel1) && bcd_digit_ok(sel0));

    // rejection flag is decided at grant time and held until the next grant
    always_comb begin
        err_d = take ? bad : err_q;
    end

    // rejection flag register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) err_q <= 1'b0;
        else            err_q <= err_d;
    end

    assign o_err = err_q && (state_q == DONE);
`else
    assign bad   = 1'b0;
    assign o_err = 1'b0;
`endif

    // next-state logic: operands are captured only on the IDLE grant
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        op1_d   = op1_q;
        op0_d   = op0_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    idx_d   = arb_idx;
                    grant_d = arb_gnt;
                    op1_d   = sel1;
                    op0_d   = sel0;
                    state_d = bad ? DONE : ISSUE;
                    res_d   = bad ? 16'h9999 : res_q;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (i_eng_done_tick) begin
                    res_d   = {i_eng_bcd3, i_eng_bcd2, i_eng_bcd1, i_eng_bcd0};
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, all cleared by the async reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            op1_q   <= '0;
            op0_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            op1_q   <= op1_d;
            op0_q   <= op0_d;
            res_q   <= res_d;
        end
    end

    assign o_grant      = grant_q;
    assign o_done       = (state_q == DONE) ? grant_q : '0;
    assign o_busy       = state_q != IDLE;
    assign o_eng_start  = state_q == ISSUE;
    assign o_eng_bcd1_n = op1_q;
    assign o_eng_bcd0_n = op0_q;
    assign {o_bcd3, o_bcd2, o_bcd1, o_bcd0} = res_q;

endmodule

// File: doc/fibb_scheduler.md
FIBB_SCHEDULER -- requirements
Module: fibb_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter IDX_W, default 2, requester index width, equal to clog2(N_REQ).
REQ-003 Port i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port i_req  input  N_REQ  per-requester request level, held until matching o_done bit pulses.
REQ-006 Port i_bcd1_n, i_bcd0_n  input  4*N_REQ each  per-requester BCD operand; requester k uses slice [4k+3:4k].
REQ-007 Port o_grant  output  N_REQ  one-hot owner of the engine; all-zero when idle.
REQ-008 Port o_done  output  N_REQ  one-cycle completion tick to the owner.
REQ-009 Port o_bcd3, o_bcd2, o_bcd1, o_bcd0  output  4 each  registered result, valid when o_done is nonzero, then held.
REQ-010 Port o_err  output  1  one-cycle tick coincident with o_done when the request was rejected.
REQ-011 Port o_busy  output  1  high in every state except IDLE.
REQ-012 Engine-side ports: o_eng_start out 1, o_eng_bcd1_n/o_eng_bcd0_n out 4 each; i_eng_ready in 1, i_eng_done_tick in 1, i_eng_bcd3..0 in 4 each.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-014 IDLE: when i_eng_ready=1 and i_req nonzero, the block SHALL latch the round-robin winner index, its operands and o_grant, then go to ISSUE.
REQ-015 Round-robin: search starts at pointer ptr and wraps past N_REQ-1 to 0; after each DONE, ptr = winner+1 mod N_REQ.
REQ-016 ISSUE: o_eng_start=1 for exactly one cycle with the latched operands on o_eng_bcd*; next state is WAIT.
REQ-017 WAIT: on i_eng_done_tick, the block SHALL register i_eng_bcd3..0 into o_bcd3..0 and go to DONE; there is no timeout.
REQ-018 DONE: o_done[winner]=1 for one cycle, o_grant cleared on exit, next state IDLE.
REQ-019 Minimum request-to-o_start latency is 1 cycle; DONE follows the engine done tick by 1 cycle.
REQ-020 Operands SHALL be sampled only in IDLE; input changes after the grant have no effect.
REQ-021 A requester that drops i_req before its o_done still completes; its done tick is still issued.
REQ-022 Simultaneous requests SHALL be served one per transaction in rotation; no requester waits more than N_REQ-1 transactions.
REQ-023 i_eng_done_tick outside WAIT SHALL be ignored.
REQ-024 o_eng_start SHALL NOT be asserted while i_eng_ready=0 in IDLE.

Reset
REQ-025 When i_reset_n=0, all of the following SHALL clear asynchronously: state=IDLE, ptr=0, o_grant=0, o_done=0, o_err=0, o_eng_start=0, o_bcd3..0=0, o_busy=0.
REQ-026 A reset mid-transaction SHALL abandon it without issuing o_done; the engine is reset externally on the same net.

Configuration
REQ-027 With macro FIBB_SCHED_BCD_CHECK_EN defined, a granted request with any operand digit >9 SHALL skip ISSUE/WAIT, go directly to DONE with o_bcd3..0=9,9,9,9 and o_err=1.
REQ-028 Without FIBB_SCHED_BCD_CHECK_EN, operands SHALL be forwarded unchecked and o_err SHALL be tied to 0.

Structure
REQ-029 State encodings and the default N_REQ SHALL live in the shared package fibb_pkg.
REQ-030 Round-robin selection SHALL be one sub-module, rr_arbiter, which is combinational (req, ptr -> one-hot grant and index).

Verification
REQ-031 Single requester: req[0], operands 1,0 (n=10), engine returns 0055 -> one o_eng_start, o_done=0001, o_bcd=0,0,5,5.
REQ-032 All four requesters asserted from reset -> service order 0,1,2,3,0, one o_done tick each, o_grant always one-hot.
REQ-033 After req[2] is served, req[1] and req[3] are asserted together -> 3 is served before 1.
REQ-034 i_eng_ready=0 while req is pending -> no o_eng_start until ready=1, then o_start in the following cycle.
REQ-035 i_reset_n pulsed low during WAIT -> all outputs 0 immediately, no o_done; a new request afterward is granted from ptr=0.
REQ-036 With FIBB_SCHED_BCD_CHECK_EN defined, operand digit 0xA -> no o_eng_start, o_done and o_err tick together, o_bcd=9,9,9,9.
